// File: rtl/controle_abastecimento.sv
// Supervisor for two water tanks (A, B) that share one supply pump.
// It arbitrates which tank fills, drives the inlet valves and the pump,
// keeps the pump off for a dead time between fills, and latches a sticky
// fault for each tank when a fill stalls or the float sensor disagrees
// with the level count.
// Build option: define LOW_LEVEL_PRIORITY_EN to break ties in favour of
// the tank with the strictly lower level. Equal levels still fall back to
// round-robin.
module controle_abastecimento #(
  parameter int unsigned REFILL_LEVEL = 3,
  parameter int unsigned FILL_TIMEOUT = 64,
  parameter int unsigned SWITCH_GAP   = 4,
  parameter int unsigned UPPER_MIN    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] level_a,
  input  logic       upper_a,
  input  logic [2:0] level_b,
  input  logic       upper_b,
  input  logic       ack_erro,
  output logic       valve_a,
  output logic       valve_b,
  output logic       pump,
  output logic       busy,
  output logic       erro_a,
  output logic       erro_b
);

  localparam int unsigned LVL_W   = 3;
  localparam int unsigned STALL_W = $clog2(FILL_TIMEOUT + 1);
  localparam int unsigned GAP_W   = $clog2(SWITCH_GAP + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = '1;

  typedef enum logic [1:0] {IDLE, FILL_A, FILL_B, SETTLE} state_t;

  state_t             state, state_next;
  logic               rr_last, rr_next;          // 1 = tank B was served last
  logic [STALL_W-1:0] stall_cnt, stall_next, stall_inc;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic [LVL_W-1:0]   level_a_q, level_b_q;

  logic req_a, req_b, tie_a, grant_a;
  logic sens_err_a, sens_err_b;
  logic set_err_a, set_err_b;
  logic timeout_a, timeout_b;
  logic valve_a_d, valve_b_d, pump_d, busy_d, erro_a_d, erro_b_d;

  // Fill requests and float-sensor consistency checks
  always_comb begin
    req_a      = enable & ~upper_a & (level_a <= LVL_W'(REFILL_LEVEL)) & ~erro_a;
    req_b      = enable & ~upper_b & (level_b <= LVL_W'(REFILL_LEVEL)) & ~erro_b;
    sens_err_a = upper_a & (level_a < LVL_W'(UPPER_MIN));
    sens_err_b = upper_b & (level_b < LVL_W'(UPPER_MIN));
    stall_inc  = (stall_cnt == STALL_W'(FILL_TIMEOUT)) ? stall_cnt
                                                       : stall_cnt + STALL_W'(1);
  end

  // Tie-break when both tanks request in the same cycle
`ifdef LOW_LEVEL_PRIORITY_EN
  always_comb begin
    if (level_a < level_b)      tie_a = 1'b1;
    else if (level_b < level_a) tie_a = 1'b0;
    else                        tie_a = rr_last;
  end
`else
  always_comb begin
    tie_a = rr_last;
  end
`endif

  assign grant_a = req_a & (~req_b | tie_a);

  // Next-state logic, stall and dead-time counters
  always_comb begin
    state_next = state;
    stall_next = stall_cnt;
    gap_next   = gap_cnt;
    rr_next    = rr_last;
    timeout_a  = 1'b0;
    timeout_b  = 1'b0;
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          state_next = grant_a ? FILL_A : FILL_B;
          stall_next = '0;
        end
      end
      FILL_A: begin
        stall_next = (level_a > level_a_q) ? '0 : stall_inc;
        timeout_a  = (stall_next == STALL_W'(FILL_TIMEOUT));
        if (upper_a | (level_a == LVL_FULL) | ~enable | timeout_a) begin
          state_next = SETTLE;
          gap_next   = '0;
          rr_next    = 1'b0;
        end
      end
      FILL_B: begin
        stall_next = (level_b > level_b_q) ? '0 : stall_inc;
        timeout_b  = (stall_next == STALL_W'(FILL_TIMEOUT));
        if (upper_b | (level_b == LVL_FULL) | ~enable | timeout_b) begin
          state_next = SETTLE;
          gap_next   = '0;
          rr_next    = 1'b1;
        end
      end
      SETTLE: begin
        if (gap_cnt == GAP_W'(SWITCH_GAP - 1)) state_next = IDLE;
        else                                   gap_next   = gap_cnt + GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
    set_err_a = sens_err_a | timeout_a;
    set_err_b = sens_err_b | timeout_b;
  end

  // Next output values; valve opens on entry, pump follows one cycle later
  always_comb begin
    valve_a_d = (state_next == FILL_A);
    valve_b_d = (state_next == FILL_B);
    pump_d    = ((state == FILL_A) & (state_next == FILL_A)) |
                ((state == FILL_B) & (state_next == FILL_B));
    busy_d    = (state_next != IDLE);
    erro_a_d  = set_err_a | (erro_a & ~ack_erro);
    erro_b_d  = set_err_b | (erro_b & ~ack_erro);
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      stall_cnt <= '0;
      gap_cnt   <= '0;
      level_a_q <= '0;
      level_b_q <= '0;
      valve_a   <= 1'b0;
      valve_b   <= 1'b0;
      pump      <= 1'b0;
      busy      <= 1'b0;
      erro_a    <= 1'b0;
      erro_b    <= 1'b0;
    end else begin
      state     <= state_next;
      rr_last   <= rr_next;
      stall_cnt <= stall_next;
      gap_cnt   <= gap_next;
      level_a_q <= level_a;
      level_b_q <= level_b;
      valve_a   <= valve_a_d;
      valve_b   <= valve_b_d;
      pump      <= pump_d;
      busy      <= busy_d;
      erro_a    <= erro_a_d;
      erro_b    <= erro_b_d;
    end
  end

endmodule

// File: tb/tb_controle_abastecimento.sv
// Directed bench for controle_abastecimento. Outputs are compared as the
// packed vector {valve_a, valve_b, pump, busy, erro_a, erro_b}.
module tb_controle_abastecimento;

  logic       clock = 1'b0;
  logic       reset, enable, upper_a, upper_b, ack_erro;
  logic [2:0] level_a, level_b;
  logic       valve_a, valve_b, pump, busy, erro_a, erro_b;

  int checks = 0;
  int errors = 0;

  controle_abastecimento dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .level_a  (level_a),
    .upper_a  (upper_a),
    .level_b  (level_b),
    .upper_b  (upper_b),
    .ack_erro (ack_erro),
    .valve_a  (valve_a),
    .valve_b  (valve_b),
    .pump     (pump),
    .busy     (busy),
    .erro_a   (erro_a),
    .erro_b   (erro_b)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {valve_a, valve_b, pump, busy, erro_a, erro_b};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ack_erro = 1'b0;
    level_a = 3'd6; upper_a = 1'b0; level_b = 3'd6; upper_b = 1'b0;
    tick(2);
    chk("reset", 6'b000000);
    reset = 1'b0;

    // Single request on A, completed by the upper sensor
    level_a = 3'd2;
    tick(); chk("a_valve_first", 6'b100100);
    tick(); chk("a_pump_second", 6'b101100);
    upper_a = 1'b1; level_a = 3'd6;
    tick(); chk("a_upper_exit", 6'b000100);
    tick(3); chk("a_settle_last", 6'b000100);
    tick(); chk("a_idle", 6'b000000);
    upper_a = 1'b0;

    // Both at level 1 from reset: A first, then round-robin alternation
    reset = 1'b1; tick(); reset = 1'b0;
    level_a = 3'd1; level_b = 3'd1;
    tick(); chk("tie_a_first", 6'b100100);
    tick(); chk("tie_a_pump", 6'b101100);
    level_a = 3'd7;
    tick(); chk("a_full_exit", 6'b000100);
    level_a = 3'd1;
    tick(3); chk("gap_busy", 6'b000100);
    tick(); chk("gap_idle", 6'b000000);
    tick(); chk("rr_b_granted", 6'b010100);
    tick(); chk("rr_b_pump", 6'b011100);
    level_b = 3'd7;
    tick(); chk("b_full_exit", 6'b000100);
    level_b = 3'd1;
    tick(4); chk("gap2_idle", 6'b000000);
    tick(); chk("rr_a_granted", 6'b100100);
    level_a = 3'd7; level_b = 3'd6;
    tick(); chk("a_full_exit2", 6'b000100);
    tick(4); chk("idle_before_stall", 6'b000000);

    // Stalled fill on A
    level_a = 3'd2;
    tick(); chk("stall_entry", 6'b100100);
    tick(63); chk("stall_pre_timeout", 6'b101100);
    tick(); chk("stall_timeout", 6'b000110);
    tick(4); chk("stall_settle_done", 6'b000010);
    tick(3); chk("no_regrant_erro", 6'b000010);
    ack_erro = 1'b1;
    tick(); chk("ack_clears_a", 6'b000000);
    ack_erro = 1'b0;
    tick(); chk("regrant_a", 6'b100100);
    tick(); chk("regrant_pump", 6'b101100);

    // Enable dropped mid-fill
    enable = 1'b0;
    tick(); chk("abort_exit", 6'b000100);
    tick(3); chk("abort_settle", 6'b000100);
    tick(); chk("abort_idle", 6'b000000);
    enable = 1'b1; level_a = 3'd6;

    // Inconsistent sensor on B while idle and during a fill
    upper_b = 1'b1; level_b = 3'd3;
    tick(); chk("sensor_idle_b", 6'b000001);
    upper_b = 1'b0; level_b = 3'd6; ack_erro = 1'b1;
    tick(); chk("ack_clears_b", 6'b000000);
    ack_erro = 1'b0; level_b = 3'd2;
    tick(); chk("b_fill", 6'b010100);
    tick(); chk("b_fill_pump", 6'b011100);
    upper_b = 1'b1; level_b = 3'd3;
    tick(); chk("sensor_fill_b", 6'b000101);
    ack_erro = 1'b1;
    tick(); chk("error_beats_ack", 6'b000101);
    upper_b = 1'b0; level_b = 3'd6;
    tick(); chk("ack_after_clear", 6'b000100);
    ack_erro = 1'b0;
    tick(2); chk("sensor_idle_end", 6'b000000);

    // Reset in the middle of a B fill
    level_b = 3'd2;
    tick(2); chk("b_fill_before_reset", 6'b011100);
    reset = 1'b1; level_b = 3'd6;
    tick(); chk("reset_mid_fill", 6'b000000);
    reset = 1'b0;

    // Tie with unequal levels
    level_a = 3'd3; level_b = 3'd0;
    tick();
`ifdef LOW_LEVEL_PRIORITY_EN
    chk("tie_low_level", 6'b010100);
`else
    chk("tie_round_robin", 6'b100100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
